// File: rtl/receiver.sv
// Serial receiver: oversampled, idle-high line, 8N1 framing by default.
// The start bit is validated at mid-bit, data bits are shifted in LSB first,
// and the stop bit is checked before the byte is presented with a one-cycle
// strobe.
// Optional feature: define RX_PARITY_EN to add an even-parity bit between the
// data bits and the stop bit. When it is undefined, the frame is 10 bits and
// parity_error is tied low.

module receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 receive_enable,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 character_received,
    output logic                 framing_error,
    output logic                 parity_error
);

    localparam int BSC_W = $clog2(OVERSAMPLE);
    localparam int BIC_W = $clog2(DATA_BITS + 1);

    // bsc value at which the start bit is re-checked (mid-bit)
    localparam logic [BSC_W-1:0] BSC_HALF = BSC_W'(OVERSAMPLE / 2 - 1);
    // bsc value at which data/parity/stop bits are sampled (one bit after mid-bit)
    localparam logic [BSC_W-1:0] BSC_LAST = BSC_W'(OVERSAMPLE - 1);
    localparam logic [BIC_W-1:0] BIC_LAST = BIC_W'(DATA_BITS - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    // Two-flop synchronizer. Both flops reset to idle-high.
    logic sync_meta_d, sync_meta_q;
    logic sync_rx_d, sync_rx_q;
    logic rx;

    state_t                 state_d, state_q;
    logic [BSC_W-1:0]       bsc_d, bsc_q;
    logic [BIC_W-1:0]       bic_d, bic_q;
    logic [DATA_BITS-1:0]   shift_d, shift_q;
    logic [DATA_BITS-1:0]   data_out_d, data_out_q;
    logic                   char_rcvd_d, char_rcvd_q;
    logic                   frame_err_d, frame_err_q;

`ifdef RX_PARITY_EN
    logic                   par_bit_d, par_bit_q;
    logic                   par_err_d, par_err_q;
    logic                   par_bad;
`endif

    // Synchronizer next-state: the line is simply shifted through two stages.
    always_comb begin
        sync_meta_d = data_in;
        sync_rx_d   = sync_meta_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= 1'b1;
            sync_rx_q   <= 1'b1;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_rx_q   <= sync_rx_d;
        end
    end

    assign rx = sync_rx_q;

`ifdef RX_PARITY_EN
    // Even parity: data bits plus the parity bit must XOR to zero.
    assign par_bad = (^shift_q) ^ par_bit_q;
`endif

    // FSM next-state, counters, shift register and output strobes.
    always_comb begin
        state_d     = state_q;
        bsc_d       = bsc_q;
        bic_d       = bic_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        char_rcvd_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
        par_bit_d   = par_bit_q;
        par_err_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                bsc_d = '0;
                bic_d = '0;
                // receive_enable only gates the start of a new frame.
                if (!rx && receive_enable) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bsc_q == BSC_HALF) begin
                    bsc_d = '0;
                    bic_d = '0;
                    if (!rx) begin
                        state_d = S_DATA;
                    end else begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    bsc_d = bsc_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bsc_q == BSC_LAST) begin
                    shift_d = {rx, shift_q[DATA_BITS-1:1]};
                    bsc_d   = '0;
                    bic_d   = bic_q + 1'b1;
                    if (bic_q == BIC_LAST) begin
`ifdef RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    bsc_d = bsc_q + 1'b1;
                end
            end

`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (bsc_q == BSC_LAST) begin
                    par_bit_d = rx;
                    bsc_d     = '0;
                    state_d   = S_STOP;
                end else begin
                    bsc_d = bsc_q + 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (bsc_q == BSC_LAST) begin
                    bsc_d   = '0;
                    bic_d   = '0;
                    state_d = S_IDLE;
                    if (rx) begin
`ifdef RX_PARITY_EN
                        if (par_bad) begin
                            par_err_d = 1'b1;
                        end else begin
                            data_out_d  = shift_q;
                            char_rcvd_d = 1'b1;
                        end
`else
                        data_out_d  = shift_q;
                        char_rcvd_d = 1'b1;
`endif
                    end else begin
                        // A bad stop bit wins over any parity result.
                        frame_err_d = 1'b1;
                    end
                end else begin
                    bsc_d = bsc_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                bsc_d   = '0;
                bic_d   = '0;
            end
        endcase
    end

    // FSM, counter, data and strobe registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bsc_q       <= '0;
            bic_q       <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            char_rcvd_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bsc_q       <= bsc_d;
            bic_q       <= bic_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            char_rcvd_q <= char_rcvd_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef RX_PARITY_EN
    // Parity bit capture and parity error strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
        end
    end

    assign parity_error = par_err_q;
`else
    assign parity_error = 1'b0;
`endif

    assign data_out           = data_out_q;
    assign character_received = char_rcvd_q;
    assign framing_error      = frame_err_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: reset values, good frames, glitch rejection,
// framing error, back-to-back frames, mid-frame reset, receive_enable gating
// and (with RX_PARITY_EN) parity checking.

module tb_receiver;

    localparam int OS = 16;
`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Line falls just after posedge c; sync adds 2 edges, IDLE sees it at c+3,
    // stop sampled 8 + 16*(FRAME_BITS-1) edges later, pulse visible after it.
    localparam int PULSE_LAT = 3 + OS / 2 + OS * (FRAME_BITS - 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic       receive_enable;
    logic [7:0] data_out;
    logic       character_received;
    logic       framing_error;
    logic       parity_error;

    receiver #(
        .DATA_BITS (8),
        .OVERSAMPLE(OS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .data_in           (data_in),
        .receive_enable    (receive_enable),
        .data_out          (data_out),
        .character_received(character_received),
        .framing_error     (framing_error),
        .parity_error      (parity_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int cr_cnt   = 0;
    int fe_cnt   = 0;
    int pe_cnt   = 0;
    int both_cnt = 0;
    int start_cyc = 0;
    int         cr_cyc[$];
    logic [7:0] cr_data[$];

    always @(negedge clk) begin
        if (character_received === 1'b1) begin
            cr_cnt++;
            cr_cyc.push_back(cyc);
            cr_data.push_back(data_out);
        end
        if (framing_error === 1'b1) fe_cnt++;
        if (parity_error === 1'b1) pe_cnt++;
        if (character_received === 1'b1 && framing_error === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        data_in = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip_par);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit((^d) ^ flip_par);
`else
        if (flip_par) data_in = 1'b1;
`endif
        drive_bit(stop_bit);
        data_in = 1'b1;
    endtask

    int n_cr, n_fe, n_pe;

    task automatic snap();
        n_cr = cr_cnt;
        n_fe = fe_cnt;
        n_pe = pe_cnt;
    endtask

    initial begin
        rst            = 1'b1;
        data_in        = 1'b1;
        receive_enable = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_char_rcvd", 32'(character_received), 32'h0);
        check("rst_frame_err", 32'(framing_error), 32'h0);
        check("rst_parity_err", 32'(parity_error), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Good frame 0x9B with pulse timing
        snap();
        send_frame(8'h9B, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("f9b_cr_count", 32'(cr_cnt - n_cr), 32'd1);
        check("f9b_fe_count", 32'(fe_cnt - n_fe), 32'd0);
        check("f9b_data", 32'(data_out), 32'h9B);
        check("f9b_latency", 32'(cr_cyc[n_cr] - start_cyc), 32'(PULSE_LAT));

        // Short low glitch: start rejected at mid-bit
        snap();
        data_in = 1'b0;
        repeat (4) @(negedge clk);
        data_in = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_cr", 32'(cr_cnt - n_cr), 32'd0);
        check("glitch_fe", 32'(fe_cnt - n_fe), 32'd0);
        check("glitch_data", 32'(data_out), 32'h9B);

        // 0x3C with stop bit low
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        check("ferr_fe_count", 32'(fe_cnt - n_fe), 32'd1);
        check("ferr_cr_count", 32'(cr_cnt - n_cr), 32'd0);
        check("ferr_data_hold", 32'(data_out), 32'h9B);

        // Back-to-back 0x55, 0xAA
        snap();
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_cr_count", 32'(cr_cnt - n_cr), 32'd2);
        check("b2b_first", 32'(cr_data[n_cr]), 32'h55);
        check("b2b_second", 32'(cr_data[n_cr + 1]), 32'hAA);
        check("b2b_gap", 32'(cr_cyc[n_cr + 1] - cr_cyc[n_cr]), 32'(FRAME_BITS * OS));
        check("b2b_data", 32'(data_out), 32'hAA);

        // Reset during bit 4 of 0xF0
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        data_in = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_cr", 32'(character_received), 32'h0);
        check("mid_rst_fe", 32'(framing_error), 32'h0);
        check("mid_rst_pe", 32'(parity_error), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        snap();
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("post_rst_cr", 32'(cr_cnt - n_cr), 32'd1);
        check("post_rst_data", 32'(data_out), 32'h0F);

        // receive_enable low over a whole frame
        receive_enable = 1'b0;
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("dis_cr", 32'(cr_cnt - n_cr), 32'd0);
        check("dis_fe", 32'(fe_cnt - n_fe), 32'd0);
        check("dis_pe", 32'(pe_cnt - n_pe), 32'd0);
        check("dis_data", 32'(data_out), 32'h0F);
        receive_enable = 1'b1;
        repeat (4) @(negedge clk);

`ifdef RX_PARITY_EN
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("par_ok_cr", 32'(cr_cnt - n_cr), 32'd1);
        check("par_ok_pe", 32'(pe_cnt - n_pe), 32'd0);
        check("par_ok_data", 32'(data_out), 32'hA5);

        snap();
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("par_bad_pe", 32'(pe_cnt - n_pe), 32'd1);
        check("par_bad_cr", 32'(cr_cnt - n_cr), 32'd0);
        check("par_bad_data", 32'(data_out), 32'hA5);
`else
        check("no_par_pe_total", 32'(pe_cnt), 32'd0);
`endif

        check("cr_fe_exclusive", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
